// File: rtl/multiband_equalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multiband_equalizer                                          |
// | Description : N-band audio equalizer. A cascade of one-pole shift low-pass |
// |               filters splits each accepted sample into complementary bands |
// |               that are weighted by programmable signed fixed-point gains   |
// |               in a time-multiplexed MAC. Gains are written byte-wise into  |
// |               staging registers and committed only when a sample is taken. |
// |               Build option EQ_SATURATE_EN: clamp the result to the DATA_W  |
// |               range instead of wrapping it.                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multiband_equalizer #(
  parameter int DATA_W    = 24,
  parameter int NUM_BANDS = 4,
  parameter int GAIN_W    = 24,
  parameter int FRAC_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_in,
  input  logic [DATA_W-1:0] audio_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid
);

  localparam int SW     = DATA_W + 2;           // filter state width
  localparam int BYTES  = GAIN_W / 8;           // bytes per gain register
  localparam int IDX_W  = $clog2(NUM_BANDS);
  localparam int PROD_W = SW + GAIN_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILT = 2'd1,
    S_MAC  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [GAIN_W-1:0]        gain_stg_q [NUM_BANDS];
  logic [GAIN_W-1:0]        gain_act_q [NUM_BANDS];
  logic                     byp_stg_q, byp_act_q;
  logic signed [SW-1:0]     lf_q [NUM_BANDS];  // lf_q[0] holds the captured sample
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        audio_out_q;
  logic                     out_valid_q;

  logic                     w_accept;
  logic                     w_mac_last;
  logic [IDX_W-1:0]         w_prev_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic signed [SW-1:0]     w_diff;
  logic signed [SW-1:0]     w_filt;
  logic signed [SW-1:0]     w_band;
  logic signed [PROD_W-1:0] w_band_x;
  logic signed [PROD_W-1:0] w_gain_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0]        w_eq;
  logic [DATA_W-1:0]        w_result;

  // FSM next state, band index sequencing and the ready handshake
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_ready   = 1'b0;
    w_accept   = 1'b0;
    w_mac_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          state_d  = S_FILT;
          idx_d    = IDX_W'(1);
        end
      end
      S_FILT: begin
        if (idx_q == LAST) begin
          state_d = S_MAC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_MAC: begin
        if (idx_q == LAST) begin
          w_mac_last = 1'b1;
          state_d    = S_IDLE;
          idx_d      = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Filter step, band extraction and one MAC product for the current index
  always_comb begin
    w_prev_idx = idx_q - IDX_W'(1);
    w_next_idx = (idx_q == LAST) ? idx_q : idx_q + IDX_W'(1);
    // Stage k chases the freshly updated stage k-1 with a shift of k
    w_diff     = lf_q[w_prev_idx] - lf_q[idx_q];
    w_filt     = lf_q[idx_q] + (w_diff >>> idx_q);
    // Last band is the final low-pass output, others are adjacent differences
    w_band     = (idx_q == LAST) ? lf_q[idx_q] : (lf_q[idx_q] - lf_q[w_next_idx]);
    w_band_x   = {{GAIN_W{w_band[SW-1]}}, w_band};
    w_gain_x   = {{SW{gain_act_q[idx_q][GAIN_W-1]}}, gain_act_q[idx_q]};
    w_prod     = w_band_x * w_gain_x;
    w_sum      = acc_q + {{IDX_W{w_prod[PROD_W-1]}}, w_prod};
  end

`ifdef EQ_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] w_shift;

  // Floor-scale the sum and clamp it into the signed output range
  always_comb begin
    w_shift = w_sum >>> FRAC_W;
    if (w_shift > SAT_MAX) begin
      w_eq = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_shift < SAT_MIN) begin
      w_eq = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_eq = w_shift[DATA_W-1:0];
    end
  end
`else
  // Floor-scale the sum and keep the low DATA_W bits (two's-complement wrap)
  assign w_eq = w_sum[FRAC_W +: DATA_W];
`endif

  assign w_result  = byp_act_q ? lf_q[0][DATA_W-1:0] : w_eq;
  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;

  // FSM state and band index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Byte-wide writes into the staging copies of control and gains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_stg_q <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) gain_stg_q[k] <= UNITY;
    end else if (we) begin
      if (addr == 8'd0) byp_stg_q <= data_in[0];
      for (int k = 0; k < NUM_BANDS; k++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (addr == 8'(1 + k*BYTES + b)) gain_stg_q[k][8*b +: 8] <= data_in;
        end
      end
    end
  end

  // Active settings change only on a sample accept, so a sample never sees a half-written gain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_act_q <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) gain_act_q[k] <= UNITY;
    end else if (w_accept) begin
      byp_act_q  <= byp_stg_q;
      gain_act_q <= gain_stg_q;
    end
  end

  // Capture the sample on accept, then advance one filter stage per FILT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) lf_q[k] <= '0;
    end else if (w_accept) begin
      lf_q[0] <= {{2{audio_in[DATA_W-1]}}, audio_in};
    end else if (state_q == S_FILT) begin
      lf_q[idx_q] <= w_filt;
    end
  end

  // Accumulate band products and publish the result on the last MAC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (w_accept) begin
        acc_q <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= w_sum;
        if (w_mac_last) begin
          audio_out_q <= w_result;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiband_equalizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multiband_equalizer                                       |
// | Description : Directed self-checking bench for multiband_equalizer with    |
// |               hand-computed expected values.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multiband_equalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic [23:0] audio_in;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] audio_out;
  logic        out_valid;

  int n_err = 0;
  int n_chk = 0;
  int lat;
  int lows;
  int rdy_at_valid;
  int bad;
  logic signed [23:0] y;
  logic signed [23:0] exp_sat;

  multiband_equalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .audio_in  (audio_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .audio_out (audio_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic set_gain(input int k, input logic [23:0] g);
    for (int b = 0; b < 3; b++) write_reg(8'(1 + k*3 + b), g[8*b +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one sample (optionally with a register write on the accept edge),
  // then measure latency and in_ready behaviour up to out_valid (bounded)
  task automatic run_sample(input logic [23:0] x, input logic wr,
                            input logic [7:0] wa, input logic [7:0] wd);
    @(negedge clk);
    audio_in = x; in_valid = 1'b1;
    we = wr; addr = wa; data_in = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; we = 1'b0;
    lat = 0; lows = 0; rdy_at_valid = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        rdy_at_valid = int'(in_ready);
      end else if (!in_ready) begin
        lows++;
      end
    end
    y = audio_out;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = 8'd0; data_in = 8'd0;
    audio_in = 24'd0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_audio_out", audio_out, 0);

    // Unity gains: output equals input, latency 8, in_ready low for 7 cycles
    for (int i = 0; i < 6; i++) begin
      run_sample(24'(i*500), 1'b0, 8'd0, 8'd0);
      check_eq("ramp_out", y, i*500);
      check_eq("ramp_latency", lat, 8);
      check_eq("ramp_ready_low", lows, 7);
      check_eq("ramp_ready_at_valid", rdy_at_valid, 1);
    end

    // All gains zero
    for (int a = 1; a <= 12; a++) write_reg(8'(a), 8'h00);
    run_sample(24'd12345, 1'b0, 8'd0, 8'd0);
    check_eq("zero_gain", y, 0);

    // All gains 2.0 on full-scale input: 2x overflows the output range
    for (int k = 0; k < 4; k++) set_gain(k, 24'h000020);
    run_sample(24'h7FFFFF, 1'b0, 8'd0, 8'd0);
`ifdef EQ_SATURATE_EN
    exp_sat = 24'h7FFFFF;
`else
    exp_sat = 24'hFFFFFE;
`endif
    check_eq("gain2_fullscale", y, exp_sat);

    // Only band3 with gain -1.0, constant 1000 from cleared filter state.
    // First sample: L1=500, L2=125, L3=15 -> -15.
    // Floor shifts stall the chain at L1=999, L2=996, L3=989 -> -989.
    do_reset();
    for (int k = 0; k < 3; k++) set_gain(k, 24'h000000);
    set_gain(3, 24'hFFFFF0);
    for (int i = 0; i < 200; i++) begin
      run_sample(24'd1000, 1'b0, 8'd0, 8'd0);
      if (i == 0) check_eq("band3_first", y, -15);
    end
    check_eq("band3_settled", y, -989);

    // Write band0 gain byte0 = 0 on the accept edge: old unity applies first.
    // Second sample: L1=750, so bands 1..3 sum to 750 with band0 muted.
    do_reset();
    run_sample(24'd1000, 1'b1, 8'd1, 8'h00);
    check_eq("same_edge_old_gain", y, 1000);
    run_sample(24'd1000, 1'b0, 8'd0, 8'd0);
    check_eq("same_edge_new_gain", y, 750);

    // Bypass ignores the (non-unity) gains
    write_reg(8'd0, 8'h01);
    run_sample(24'hFFFCF7, 1'b0, 8'd0, 8'd0);
    check_eq("bypass_neg", y, -777);
    run_sample(24'd5000, 1'b0, 8'd0, 8'd0);
    check_eq("bypass_pos", y, 5000);

    // Reset asserted in cycle t+4 of a sample aborts it
    set_gain(1, 24'h000000);
    @(negedge clk);
    audio_in = 24'd4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check_eq("abort_no_valid", bad, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_audio_out", audio_out, 0);
    // Unity gains and cleared bypass: output equals input again
    run_sample(24'd1000, 1'b0, 8'd0, 8'd0);
    check_eq("abort_unity_restored", y, 1000);
    check_eq("abort_latency", lat, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
